ws2812b_frame_timer: RTL
========================

WS2812B_FRAME_TIMER -- requirements
Module: ws2812b_frame_timer

Interface
REQ-001 Parameter BIT_CYCLES, default 63: clk cycles per WS2812B bit slot (1.25 us at 50 MHz); legal range 4..1023.
REQ-002 Parameter LATCH_CYCLES, default 2500: clk cycles of line-reset (latch) gap after a frame; legal range 2..65535.
REQ-003 Parameter PIX_W, default 10: width of pixel count and index.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level; request a frame when idle.
REQ-007 pixel_count  input  PIX_W  pixels per frame; sampled on start acceptance.
REQ-008 abort  input  1  terminate current frame early.
REQ-009 wtrig  output  1  one-cycle pulse: load next 24-bit pixel word into the downstream buffer.
REQ-010 btrig  output  1  one-cycle pulse: start of each bit slot (shift buffer, load transmitter).
REQ-011 busy  output  1  high from start acceptance through last latch cycle.
REQ-012 latch  output  1  high during the line-reset gap.
REQ-013 done  output  1  one-cycle pulse in final latch cycle.
REQ-014 pixel_idx  output  PIX_W  index of pixel currently being sent.

Function
REQ-015 FSM states IDLE, LOAD, BITS, LATCH; IDLE->LOAD on start=1 and pixel_count!=0; LOAD->BITS after one cycle; BITS->LOAD at end of bit 23 of each non-final pixel... realised as pulses per REQ-017/018 with no gap cycles; BITS->LATCH after final bit slot; LATCH->IDLE after LATCH_CYCLES.
REQ-016 Start accepted in cycle S; T0 = S+1; pixel_count captured in cycle S.
REQ-017 wtrig SHALL pulse at T0 + 24*p*BIT_CYCLES for p = 0..N-1 (N = captured count); always exactly one cycle before that pixel's first btrig.
REQ-018 btrig SHALL pulse at T0 + 1 + k*BIT_CYCLES for k = 0..24N-1; no extra or missing slots between pixels.
REQ-019 latch high from T0 + 1 + 24N*BIT_CYCLES for exactly LATCH_CYCLES cycles; done pulses in the last of them; busy falls the cycle after.
REQ-020 pixel_idx = p from its wtrig cycle until next wtrig; holds N-1 during latch; 0 in IDLE.
REQ-021 start with pixel_count=0, or start while busy: ignored, no pulses.
REQ-022 abort=1 while busy and not in LATCH: next cycle enter LATCH (full LATCH_CYCLES), no further btrig/wtrig; done still pulses. abort in LATCH or IDLE: ignored.
REQ-023 start and abort same cycle in IDLE: start wins.
REQ-024 Bit-slot counter wraps 0..BIT_CYCLES-1; bit counter 0..23; pixel counter 0..N-1; N = 2^PIX_W-1 maximum SHALL not overflow.

Reset
REQ-025 reset_n low: FSM to IDLE, all counters 0, wtrig/btrig/busy/latch/done = 0, pixel_idx = 0, immediately (asynchronous).
REQ-026 Reset mid-frame abandons the frame; no done pulse; first cycle after release is IDLE.

Configuration
REQ-027 Macro WS2812B_FRAME_REPEAT_EN defined: at end of LATCH, if start=1, go directly to LOAD (re-sampling pixel_count) with no IDLE cycle; busy stays high; done still pulses.
REQ-028 Macro undefined: LATCH always returns to IDLE; a new frame needs a further start sample in IDLE.

Structure
REQ-029 Package ws2812b_pkg holds state enum, BITS_PER_PIXEL = 24, default BIT_CYCLES and LATCH_CYCLES constants.
REQ-030 One sub-module ws2812b_period_counter: loadable down-counter with terminal tick, instanced for bit slot and latch timing.

Verification (BIT_CYCLES=4, LATCH_CYCLES=10)
REQ-031 pixel_count=1, start at S -> wtrig at S+1; btrig at S+2, S+6, ... S+94 (24 pulses); latch S+98..S+107; done at S+107; busy low S+108.
REQ-032 pixel_count=3 -> wtrig at T0, T0+96, T0+192; 72 btrig pulses, spacing exactly 4; pixel_idx 0,1,2.
REQ-033 pixel_count=0 with start -> busy, wtrig, btrig stay 0 for 200 cycles.
REQ-034 abort at T0+50 of 2-pixel frame -> no btrig/wtrig after T0+50, latch 10 cycles from T0+51, done once.
REQ-035 reset_n low at T0+30 -> all outputs 0 same cycle; after release, IDLE, no done.
REQ-036 WS2812B_FRAME_REPEAT_EN, start held, pixel_count=1 -> second wtrig in cycle after first done; no busy gap.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared types and default timing constants for the WS2812B frame timer.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BITS  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int BITS_PER_PIXEL   = 24;
  localparam int DEF_BIT_CYCLES   = 63;
  localparam int DEF_LATCH_CYCLES = 2500;
  localparam int DEF_PIX_W        = 10;

endpackage

// File: rtl/ws2812b_frame_timer_if.sv
// Control/strobe bundle between a frame requester (master) and the WS2812B frame timer (slave).
interface ws2812b_frame_timer_if
  import ws2812b_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
);
  logic             start;
  logic [PIX_W-1:0] pixel_count;
  logic             abort;
  logic             wtrig;
  logic             btrig;
  logic             busy;
  logic             latch;
  logic             done;
  logic [PIX_W-1:0] pixel_idx;

  modport master (
    output start, pixel_count, abort,
    input  wtrig, btrig, busy, latch, done, pixel_idx
  );

  modport slave (
    input  start, pixel_count, abort,
    output wtrig, btrig, busy, latch, done, pixel_idx
  );
endinterface

// File: rtl/ws2812b_period_counter.sv
// Loadable down-counter that parks at zero; tick flags the final cycle of a loaded period.
module ws2812b_period_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tick
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/ws2812b_frame_timer.sv
// WS2812B frame sequencer: word/bit strobes per pixel, then a latch gap.
// Define WS2812B_FRAME_REPEAT_EN to chain frames back-to-back while start is held.
module ws2812b_frame_timer
  import ws2812b_pkg::*;
#(
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int PIX_W        = DEF_PIX_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ws2812b_frame_timer_if.slave  bus
);

  localparam int SLOT_W  = 10;
  localparam int LATCH_W = 16;

  state_t             state;
  logic [4:0]         bit_cnt;
  logic [PIX_W-1:0]   n_cap;
  logic [PIX_W-1:0]   pix;
  logic               wtrig_q, btrig_q, busy_q, latch_q, done_q;

  logic [SLOT_W-1:0]  slot_cnt;
  logic               slot_tick;
  logic [LATCH_W-1:0] gap_cnt;
  logic               gap_tick;

  logic accept, abort_hit, last_bit, frame_end, slot_load, gap_load;

  assign accept    = bus.start && (bus.pixel_count != '0);
  assign abort_hit = bus.abort && ((state == LOAD) || (state == BITS));
  assign last_bit  = (bit_cnt == 5'(BITS_PER_PIXEL - 1));
  // wtrig is high in the closing cycle of a pixel only when another pixel follows
  assign frame_end = (state == BITS) && slot_tick && last_bit && !wtrig_q;
  assign slot_load = !abort_hit && ((state == LOAD) || ((state == BITS) && slot_tick && !frame_end));
  assign gap_load  = abort_hit || frame_end;

  ws2812b_period_counter #(.W(SLOT_W)) u_slot (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (slot_load),
    .load_val (SLOT_W'(BIT_CYCLES - 1)),
    .count    (slot_cnt),
    .tick     (slot_tick)
  );

  ws2812b_period_counter #(.W(LATCH_W)) u_gap (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (gap_load),
    .load_val (LATCH_W'(LATCH_CYCLES - 1)),
    .count    (gap_cnt),
    .tick     (gap_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      n_cap   <= '0;
      pix     <= '0;
      wtrig_q <= 1'b0;
      btrig_q <= 1'b0;
      busy_q  <= 1'b0;
      latch_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wtrig_q <= 1'b0;
      btrig_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= LOAD;
            wtrig_q <= 1'b1;
            busy_q  <= 1'b1;
            pix     <= '0;
            n_cap   <= bus.pixel_count;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state   <= LATCH;
            latch_q <= 1'b1;
          end else begin
            state   <= BITS;
            btrig_q <= 1'b1;
            bit_cnt <= '0;
          end
        end
        BITS: begin
          if (bus.abort || frame_end) begin
            state   <= LATCH;
            latch_q <= 1'b1;
          end else if (slot_tick) begin
            btrig_q <= 1'b1;
            bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
          end else if (last_bit && (slot_cnt == SLOT_W'(1)) && (pix != n_cap - PIX_W'(1))) begin
            // next word is requested in the closing cycle of the current pixel
            wtrig_q <= 1'b1;
            pix     <= pix + PIX_W'(1);
          end
        end
        LATCH: begin
          if (gap_cnt == LATCH_W'(1)) done_q <= 1'b1;
          if (gap_tick) begin
            latch_q <= 1'b0;
`ifdef WS2812B_FRAME_REPEAT_EN
            if (accept) begin
              state   <= LOAD;
              wtrig_q <= 1'b1;
              pix     <= '0;
              n_cap   <= bus.pixel_count;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              pix    <= '0;
            end
`else
            state  <= IDLE;
            busy_q <= 1'b0;
            pix    <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wtrig     = wtrig_q;
  assign bus.btrig     = btrig_q;
  assign bus.busy      = busy_q;
  assign bus.latch     = latch_q;
  assign bus.done      = done_q;
  assign bus.pixel_idx = pix;

endmodule
